// File: rtl/shiftreg_rw_ctrl.sv
// Serial write/readback sequencer for the Mic4 configuration shift register.
// Shifts data_in out MSB-first on sin/sclk, captures sout, then strobes load.
module shiftreg_rw_ctrl #(
  parameter int WIDTH   = 64,
  parameter int CLK_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             rd_only,
  input  logic [WIDTH-1:0] data_in,
  input  logic             sout,
  output logic             sclk,
  output logic             sin,
  output logic             load,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] data_out
);

  localparam int BW = $clog2(WIDTH + 1);
  localparam int DW = $clog2(CLK_DIV + 1);

  typedef enum logic [2:0] {IDLE, SHIFT_LO, SHIFT_HI, LOAD, DONE} state_t;

  state_t           state, state_n;
  logic [DW-1:0]    div_cnt, div_n;
  logic [BW-1:0]    bit_cnt, bit_n, bit_inc;
  logic [WIDTH-1:0] tx, tx_n, rx, rx_n, data_out_n;
  logic             rd_q, rd_n, pend, pend_n;
  logic             div_last;
  logic             sclk_n, sin_n, load_n, busy_n, done_n;

  assign div_last = (div_cnt == DW'(CLK_DIV - 1));
  assign bit_inc  = bit_cnt + BW'(1);

  always_comb begin
    state_n = state;
    div_n   = div_cnt;
    bit_n   = bit_cnt;
    tx_n    = tx;
    rx_n    = rx;
    rd_n    = rd_q;
    pend_n  = pend;
    case (state)
      IDLE: begin
        // Latch on start, enter SHIFT_LO one cycle later; start is ignored while pending.
        if (pend) begin
          state_n = SHIFT_LO;
          pend_n  = 1'b0;
          div_n   = '0;
          bit_n   = '0;
        end else if (start) begin
          pend_n = 1'b1;
          tx_n   = rd_only ? '0 : data_in;
          rd_n   = rd_only;
          rx_n   = '0;
        end
      end
      SHIFT_LO: begin
        if (div_last) begin
          div_n   = '0;
          state_n = SHIFT_HI;
        end else begin
          div_n = div_cnt + DW'(1);
        end
      end
      SHIFT_HI: begin
        if (div_last) begin
          div_n = '0;
          rx_n  = {rx[WIDTH-2:0], sout};
          bit_n = bit_inc;
          if (bit_inc == BW'(WIDTH)) begin
            state_n = LOAD;
          end else begin
            tx_n    = {tx[WIDTH-2:0], 1'b0};
            state_n = SHIFT_LO;
          end
        end else begin
          div_n = div_cnt + DW'(1);
        end
      end
      LOAD: begin
        if (div_last) begin
          div_n   = '0;
          state_n = DONE;
        end else begin
          div_n = div_cnt + DW'(1);
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // Outputs decoded from the next state so they leave the flops glitch-free.
    sclk_n     = (state_n == SHIFT_HI);
    sin_n      = (state_n == SHIFT_LO || state_n == SHIFT_HI) ? tx_n[WIDTH-1] : 1'b0;
    load_n     = (state_n == LOAD) && !rd_n;
    busy_n     = (state_n == SHIFT_LO || state_n == SHIFT_HI || state_n == LOAD);
    done_n     = (state_n == DONE);
    data_out_n = (state_n == DONE) ? rx_n : data_out;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      tx       <= '0;
      rx       <= '0;
      rd_q     <= 1'b0;
      pend     <= 1'b0;
      sclk     <= 1'b0;
      sin      <= 1'b0;
      load     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      data_out <= '0;
    end else begin
      state    <= state_n;
      div_cnt  <= div_n;
      bit_cnt  <= bit_n;
      tx       <= tx_n;
      rx       <= rx_n;
      rd_q     <= rd_n;
      pend     <= pend_n;
      sclk     <= sclk_n;
      sin      <= sin_n;
      load     <= load_n;
      busy     <= busy_n;
      done     <= done_n;
      data_out <= data_out_n;
    end
  end

endmodule

// File: tb/tb_shiftreg_rw_ctrl.sv
// Bench for shiftreg_rw_ctrl: WIDTH=8/CLK_DIV=2 and WIDTH=2/CLK_DIV=1 instances,
// each with a loopback chip model, checked against a cycle-offset reference model.
module tb_shiftreg_rw_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       start_a [2];
  logic       rd_a    [2];
  logic [7:0] din_a   [2];

  logic       sclk0, sin0, load0, busy0, done0, sout0;
  logic [7:0] dout0, chip0;
  logic       sclk1, sin1, load1, busy1, done1, sout1;
  logic [1:0] dout1, chip1;

  shiftreg_rw_ctrl #(.WIDTH(8), .CLK_DIV(2)) u_dut0 (
    .clk(clk), .rst(rst), .start(start_a[0]), .rd_only(rd_a[0]), .data_in(din_a[0]),
    .sout(sout0), .sclk(sclk0), .sin(sin0), .load(load0), .busy(busy0), .done(done0),
    .data_out(dout0));

  shiftreg_rw_ctrl #(.WIDTH(2), .CLK_DIV(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_a[1]), .rd_only(rd_a[1]), .data_in(din_a[1][1:0]),
    .sout(sout1), .sclk(sclk1), .sin(sin1), .load(load1), .busy(busy1), .done(done1),
    .data_out(dout1));

  // Chip: shifts sin in on sclk rise; sout presents the MSB, updated on sclk fall.
  always @(posedge sclk0 or negedge rst)
    if (!rst) chip0 <= '0; else chip0 <= {chip0[6:0], sin0};
  always @(negedge sclk0 or negedge rst)
    if (!rst) sout0 <= 1'b0; else sout0 <= chip0[7];
  always @(posedge sclk1 or negedge rst)
    if (!rst) chip1 <= '0; else chip1 <= {chip1[0], sin1};
  always @(negedge sclk1 or negedge rst)
    if (!rst) sout1 <= 1'b0; else sout1 <= chip1[1];

  int         rises0 = 0, rises1 = 0;
  logic [7:0] slog0 = '0;
  logic [1:0] slog1 = '0;
  always @(posedge sclk0) begin rises0 <= rises0 + 1; slog0 <= {slog0[6:0], sin0}; end
  always @(posedge sclk1) begin rises1 <= rises1 + 1; slog1 <= {slog1[0], sin1}; end

  logic [4:0] ctl_a  [2];
  logic [7:0] dout_a [2];
  assign ctl_a[0]  = {sclk0, sin0, load0, busy0, done0};
  assign ctl_a[1]  = {sclk1, sin1, load1, busy1, done1};
  assign dout_a[0] = dout0;
  assign dout_a[1] = {6'b0, dout1};

  // Reference model: a transaction accepted at edge k is described by its offset t from k.
  bit         act  [2];
  int         tt   [2];
  bit         m_rd [2];
  logic [7:0] m_tx [2], m_rx [2], m_dout [2], m_chip [2];

  function automatic int wd(input int i); return (i == 0) ? 8 : 2; endfunction
  function automatic int dv(input int i); return (i == 0) ? 2 : 1; endfunction
  function automatic int tdone(input int i); return 2 * wd(i) * dv(i) + dv(i) + 1; endfunction
  function automatic logic [7:0] msk(input int i, input logic [7:0] v);
    return (i == 0) ? v : {6'b0, v[1:0]};
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        act[i] = 1'b0; tt[i] = 0; m_rd[i] = 1'b0;
        m_tx[i] = '0; m_rx[i] = '0; m_dout[i] = '0; m_chip[i] = '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (act[i]) begin
          tt[i]++;
          if (tt[i] == tdone(i)) m_dout[i] = m_rx[i];
          else if (tt[i] > tdone(i)) act[i] = 1'b0;
        end else if (start_a[i] === 1'b1) begin
          act[i]    = 1'b1;
          tt[i]     = 0;
          m_rd[i]   = rd_a[i];
          m_tx[i]   = rd_a[i] ? 8'h00 : msk(i, din_a[i]);
          m_rx[i]   = m_chip[i];
          m_chip[i] = m_tx[i];
        end
      end
    end
  end

  function automatic logic [4:0] exp_ctl(input int i);
    int u, b, nsh;
    nsh = 2 * wd(i) * dv(i);
    if (!act[i] || tt[i] == 0) return 5'b00000;
    if (tt[i] <= nsh) begin
      u = tt[i] - 1;
      b = u / (2 * dv(i));
      return {((u % (2 * dv(i))) >= dv(i)), m_tx[i][wd(i) - 1 - b], 1'b0, 1'b1, 1'b0};
    end
    if (tt[i] <= nsh + dv(i)) return {1'b0, 1'b0, ~m_rd[i], 1'b1, 1'b0};
    return 5'b00001;
  endfunction

  int vec = 0, errs = 0, cyc = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    vec++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    for (int i = 0; i < 2; i++) begin
      vec++;
      if (ctl_a[i] !== exp_ctl(i) || dout_a[i] !== m_dout[i]) begin
        errs++;
        $display("FAIL cycle%0d inst%0d: {sclk,sin,load,busy,done} got %b want %b, data_out got %h want %h",
                 cyc, i, ctl_a[i], exp_ctl(i), dout_a[i], m_dout[i]);
      end
    end
  endtask

  task automatic run_txn(input int i, input logic [7:0] d, input bit rd, input bit now,
                         input bit poke, output int nb, output int nl, output int ns,
                         output int off);
    nb = 0; nl = 0; ns = 0; off = -1;
    if (!now) tick();
    din_a[i] = d; rd_a[i] = rd; start_a[i] = 1'b1;
    tick();
    start_a[i] = 1'b0;
    for (int c = 1; c <= 300; c++) begin
      if (poke && c == 5) begin start_a[i] = 1'b1; din_a[i] = 8'hFF; rd_a[i] = 1'b0; end
      tick();
      start_a[i] = 1'b0;
      if (ctl_a[i][1]) nb++;
      if (ctl_a[i][2]) nl++;
      if (ctl_a[i][3]) ns++;
      if (ctl_a[i][0]) begin off = c; break; end
    end
    // A start coincident with done must be dropped.
    if (poke && off > 0) begin
      start_a[i] = 1'b1;
      tick();
      start_a[i] = 1'b0;
    end
  endtask

  int nb, nl, ns, off, r0, quiet;

  initial begin
    for (int i = 0; i < 2; i++) begin start_a[i] = 1'b0; rd_a[i] = 1'b0; din_a[i] = '0; end
    #1 rst = 1'b0;
    #1;
    check("reset_ctl0", ctl_a[0], 5'b00000);
    check("reset_ctl1", ctl_a[1], 5'b00000);
    check("reset_dout0", dout0, 8'h00);
    repeat (3) tick();
    rst = 1'b1;
    repeat (2) tick();

    // Abort a transaction while sclk is high.
    din_a[0] = 8'hA5; rd_a[0] = 1'b0; start_a[0] = 1'b1;
    tick();
    start_a[0] = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (sclk0) break;
    end
    check("abort_sclk_high", sclk0, 1'b1);
    #2 rst = 1'b0;
    #1 check("abort_async_drop", {sclk0, load0, busy0}, 3'b000);
    repeat (2) tick();
    rst = 1'b1;
    quiet = 0;
    repeat (40) begin
      tick();
      if (load0 || done0 || busy0) quiet++;
    end
    check("post_reset_quiet", quiet, 0);

    r0 = rises0;
    run_txn(0, 8'hA5, 1'b0, 1'b0, 1'b0, nb, nl, ns, off);
    check("t1_busy", nb, 34);
    check("t1_load", nl, 2);
    check("t1_done_off", off, 35);
    check("t1_dout", dout0, 8'h00);
    check("t1_rises", rises0 - r0, 8);
    check("t1_sin_seq", slog0, 8'hA5);
    check("t1_chip", chip0, 8'hA5);

    run_txn(0, 8'h3C, 1'b0, 1'b0, 1'b0, nb, nl, ns, off);
    check("t2_done_off", off, 35);
    check("t2_dout", dout0, 8'hA5);
    check("t2_chip", chip0, 8'h3C);

    run_txn(0, 8'h5A, 1'b1, 1'b0, 1'b1, nb, nl, ns, off);
    check("rd_busy", nb, 34);
    check("rd_load", nl, 0);
    check("rd_sin_ones", ns, 0);
    check("rd_done_off", off, 35);
    check("rd_dout", dout0, 8'h3C);
    check("rd_ignored_start", busy0, 1'b0);

    run_txn(0, 8'h81, 1'b0, 1'b1, 1'b0, nb, nl, ns, off);
    check("after_done_accept", off, 35);
    check("after_done_busy", nb, 34);
    check("after_done_dout", dout0, 8'h00);
    check("after_done_sin_seq", slog0, 8'h81);

    r0 = rises1;
    run_txn(1, 8'h02, 1'b0, 1'b0, 1'b0, nb, nl, ns, off);
    check("w2_busy", nb, 5);
    check("w2_load", nl, 1);
    check("w2_done_off", off, 6);
    check("w2_rises", rises1 - r0, 2);
    check("w2_sin_seq", slog1, 2'b10);
    check("w2_dout", dout1, 2'b00);

    run_txn(1, 8'h01, 1'b0, 1'b0, 1'b0, nb, nl, ns, off);
    check("w2b_done_off", off, 6);
    check("w2b_dout", dout1, 2'b10);
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/shiftreg_rw_ctrl.md
Name: shiftreg_rw_ctrl

Overview:
- Sequences one serial write/readback transaction of the Mic4 test-chip configuration shift register, in the KC705 system-clock domain.
- A single-cycle `start` arrives already synchronised, from a pulse_synchronise instance on the host/control side.
- Each transaction:
  - shifts a parallel word out MSB-first on `sin` under a divided shift clock `sclk`;
  - captures `sout` into a parallel readback word;
  - issues a `load` strobe so the chip latches the new contents.

Parameters:
- WIDTH, 64, shift-register length in bits; legal range 2..1024.
- CLK_DIV, 4, clk cycles per `sclk` half-period; legal minimum 1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- start  input  1  one-cycle request pulse, already in the clk domain.
- rd_only  input  1  sampled with `start`; 1 = readback-only transaction.
- data_in  input  WIDTH  word to write; sampled with `start`.
- sout  input  1  serial data returned from the chip.
- sclk  output  1  shift clock to the chip.
- sin  output  1  serial data to the chip.
- load  output  1  latch strobe to the chip.
- busy  output  1  transaction in progress.
- done  output  1  one-cycle completion pulse.
- data_out  output  WIDTH  readback word; holds its value until the next `done`.

Behaviour:
- Reset (rst=0, asynchronous, any state including mid-transaction):
  - state=IDLE;
  - sclk=0, sin=0, load=0, busy=0, done=0, data_out=0;
  - bit counter and divider counter cleared.
  - No partial `load` is ever emitted after reset is released.
- States: IDLE, SHIFT_LO, SHIFT_HI, LOAD, DONE.
- IDLE:
  - start=1 at edge k: latch data_in into tx shift register (all zeros if rd_only=1) and latch rd_only.
  - Enter SHIFT_LO at k+1 with busy=1, sclk=0, sin=tx[WIDTH-1].
  - start outside IDLE is ignored; it is neither queued nor flagged.
- SHIFT_LO:
  - sclk=0 for exactly CLK_DIV cycles, then → SHIFT_HI.
- SHIFT_HI:
  - sclk=1 for exactly CLK_DIV cycles.
  - In the last cycle of the phase, sample `sout` into the LSB of the rx register, shifting left.
  - Then increment the bit counter.
  - If fewer than WIDTH bits are done: shift tx left and → SHIFT_LO; `sin` changes only on the sclk falling edge.
  - Otherwise → LOAD.
- LOAD:
  - sclk=0, sin=0.
  - load=1 for CLK_DIV cycles; load stays 0 if the latched rd_only=1, but the state duration is unchanged.
  - Then → DONE.
- DONE:
  - Lasts 1 cycle: done=1, busy=0, data_out ← rx register.
  - Next cycle → IDLE; start is accepted again from that cycle.
  - start coincident with done is ignored.
- Timing:
  - busy is high for WIDTH·2·CLK_DIV + CLK_DIV cycles.
  - done is asserted WIDTH·2·CLK_DIV + CLK_DIV + 1 cycles after the start edge.
- Outputs are registered (no combinational path from inputs to outputs).
- Counter widths: bit counter ≥ clog2(WIDTH+1); divider counter ≥ clog2(CLK_DIV+1).
- CLK_DIV=1 must work: sclk is then clk/2.

Test Plan:
- Reset → all outputs 0. Assert rst=0 mid-SHIFT_HI with sclk=1 → sclk, busy and load drop asynchronously; no load or done follows release. The next start runs a full, clean transaction.
- WIDTH=8, CLK_DIV=2, data_in=8'hA5, rd_only=0, with a loopback chip model (8-bit register shifting `sin` on sclk rise, `sout` = MSB, preloaded 8'h00) → `sin` MSB-first sequence 1,0,1,0,0,1,0,1 with each bit stable across its rising edge. Exactly 8 sclk rising edges. busy high 34 cycles; load high 2 cycles. done at start+35. data_out=8'h00.
- Second transaction data_in=8'h3C → data_out=8'hA5; model now holds 8'h3C.
- rd_only=1 with the model holding 8'h3C → sin stays 0, load never asserts, busy still 34 cycles, data_out=8'h3C.
- start pulsed during busy and again coincident with done → both ignored; exactly one done per accepted start. start in the cycle after done → accepted.
- CLK_DIV=1, WIDTH=2, data_in=2'b10 → sclk period 2 clk, busy 5 cycles, done at start+6, sin sequence 1,0.
